// File: rtl/riscy_pkg.sv
// Shared decode constants and the instruction classifier for the decode stage.
package riscy_pkg;

  localparam int unsigned XLEN  = 32;
  localparam int unsigned NREGS = 32;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;
  localparam logic [2:0] ALU_XOR = 3'b100;
  localparam logic [2:0] ALU_SLT = 3'b101;

  localparam logic [6:0] OPC_OP    = 7'b0110011;
  localparam logic [6:0] OPC_OPIMM = 7'b0010011;

  localparam logic [6:0] F7_BASE = 7'b0000000;
  localparam logic [6:0] F7_SUB  = 7'b0100000;

  localparam logic [2:0] F3_ADD = 3'b000;
  localparam logic [2:0] F3_AND = 3'b111;
  localparam logic [2:0] F3_OR  = 3'b110;
  localparam logic [2:0] F3_XOR = 3'b100;
  localparam logic [2:0] F3_SLT = 3'b010;

  typedef struct packed {
    logic       legal;
    logic [2:0] alucon;
    logic       use_rs2;
    logic       use_imm;
  } dec_t;

  // Maps funct3 to the shared OP/OP-IMM alucon; bit 3 flags a supported funct3.
  function automatic logic [3:0] f3_to_alu(input logic [2:0] f3);
    logic [3:0] r;
    r = '0;
    case (f3)
      F3_ADD:  r = {1'b1, ALU_ADD};
      F3_AND:  r = {1'b1, ALU_AND};
      F3_OR:   r = {1'b1, ALU_OR};
      F3_XOR:  r = {1'b1, ALU_XOR};
      F3_SLT:  r = {1'b1, ALU_SLT};
      default: r = '0;
    endcase
    return r;
  endfunction

  // Classifies an instruction; anything unsupported comes back all-zero (illegal, add).
  function automatic dec_t decode(input logic [31:0] instr);
    dec_t       d;
    logic [3:0] fa;
    d  = '0;
    fa = f3_to_alu(instr[14:12]);
    case (instr[6:0])
      OPC_OP: begin
        d.use_rs2 = 1'b1;
        if (instr[31:25] == F7_BASE) begin
          d.legal  = fa[3];
          d.alucon = fa[2:0];
        end else if (instr[31:25] == F7_SUB && instr[14:12] == F3_ADD) begin
          d.legal  = 1'b1;
          d.alucon = ALU_SUB;
        end
      end
      OPC_OPIMM: begin
        d.use_imm = 1'b1;
        d.legal   = fa[3];
        d.alucon  = fa[2:0];
      end
      default: d = '0;
    endcase
    if (!d.legal) d = '0;
    return d;
  endfunction

endpackage

// File: rtl/id_stage_regfile.sv
// Register file: two combinational read ports, one synchronous write port,
// x0 reads as zero and ignores writes, async active-low clear of every entry.
module regfile #(
  parameter int unsigned XLEN  = 32,
  parameter int unsigned NREGS = 32,
  parameter int unsigned AW    = $clog2(NREGS)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [AW-1:0]   ra1,
  output logic [XLEN-1:0] rd1,
  input  logic [AW-1:0]   ra2,
  output logic [XLEN-1:0] rd2,
  input  logic            we,
  input  logic [AW-1:0]   wa,
  input  logic [XLEN-1:0] wd
);

  logic [XLEN-1:0] mem [NREGS];

  // Write port with whole-array clear on reset; writes to x0 are dropped.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < NREGS; i++) mem[i] <= '0;
    end else if (we && wa != '0) begin
      mem[wa] <= wd;
    end
  end

  // Read ports, x0 forced to zero.
  always_comb begin
    rd1 = (ra1 == '0) ? '0 : mem[ra1];
    rd2 = (ra2 == '0) ? '0 : mem[ra2];
  end

endmodule

// File: rtl/id_stage.sv
// Decode / operand-fetch stage: decodes OP and OP-IMM, reads rs1/rs2 with
// write-back bypass, and holds the result in a valid/ready output register.
module id_stage
  import riscy_pkg::*;
#(
  parameter int unsigned XLEN  = riscy_pkg::XLEN,
  parameter int unsigned NREGS = riscy_pkg::NREGS
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     in_instr,
  input  logic            flush,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_a,
  output logic [XLEN-1:0] out_b,
  output logic [2:0]      out_alucon,
  output logic [4:0]      out_rd,
  output logic            out_we,
  output logic            out_illegal,
  input  logic            wb_en,
  input  logic [4:0]      wb_rd,
  input  logic [XLEN-1:0] wb_data
);

  logic [4:0]      rs1, rs2, rd;
  dec_t            dec;
  logic [XLEN-1:0] rf_rd1, rf_rd2;
  logic [XLEN-1:0] opa, opb, imm_ext;
  logic            accept;
  logic            wb_live;

  // Source indices of the held instruction, kept so a late write-back can refresh it.
  logic [4:0]      held_rs1, held_rs2;
  logic            held_use_rs1, held_use_rs2;

  assign rs1     = in_instr[19:15];
  assign rs2     = in_instr[24:20];
  assign rd      = in_instr[11:7];
  assign dec     = decode(in_instr);
  assign imm_ext = {{(XLEN-12){in_instr[31]}}, in_instr[31:20]};
  assign wb_live = wb_en && (wb_rd != '0);

  regfile #(
    .XLEN  (XLEN),
    .NREGS (NREGS),
    .AW    (5)
  ) u_rf (
    .clk   (clk),
    .rst_n (rst_n),
    .ra1   (rs1),
    .rd1   (rf_rd1),
    .ra2   (rs2),
    .rd2   (rf_rd2),
    .we    (wb_en),
    .wa    (wb_rd),
    .wd    (wb_data)
  );

  // Handshake: flush blocks input; otherwise accept whenever the output slot frees up.
  always_comb begin
    in_ready = !flush && (!out_valid || out_ready);
    accept   = in_valid && in_ready;
  end

  // Operand read with same-cycle write-back bypass (x0 never bypassed).
  always_comb begin
    opa = rf_rd1;
    opb = rf_rd2;
    if (wb_live && wb_rd == rs1) opa = wb_data;
    if (wb_live && wb_rd == rs2) opb = wb_data;
  end

  // Output pipeline register: flush beats accept beats drain beats hold/refresh.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid    <= 1'b0;
      out_a        <= '0;
      out_b        <= '0;
      out_alucon   <= ALU_ADD;
      out_rd       <= '0;
      out_we       <= 1'b0;
      out_illegal  <= 1'b0;
      held_rs1     <= '0;
      held_rs2     <= '0;
      held_use_rs1 <= 1'b0;
      held_use_rs2 <= 1'b0;
    end else if (flush) begin
      out_valid <= 1'b0;
    end else if (accept) begin
      out_valid    <= 1'b1;
      // Illegal instructions present zero operands so the outputs stay deterministic.
      out_a        <= dec.legal ? opa : '0;
      out_b        <= !dec.legal ? '0 : (dec.use_imm ? imm_ext : opb);
      out_alucon   <= dec.alucon;
      out_rd       <= rd;
      out_we       <= dec.legal && (rd != '0);
      out_illegal  <= !dec.legal;
      held_rs1     <= rs1;
      held_rs2     <= rs2;
      held_use_rs1 <= dec.legal;
      held_use_rs2 <= dec.legal && dec.use_rs2;
    end else if (out_valid && out_ready) begin
      out_valid <= 1'b0;
    end else if (out_valid) begin
      if (wb_live && held_use_rs1 && wb_rd == held_rs1) out_a <= wb_data;
      if (wb_live && held_use_rs2 && wb_rd == held_rs2) out_b <= wb_data;
    end
  end

endmodule
